// File: rtl/demux_1_to_2_stream_if.sv
// rtl/demux_1_to_2_stream_if.sv - stream bundle for the 1-to-2 packet demultiplexer
interface demux_1_to_2_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             sel;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_last;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_last;
  logic             b_ready;
  logic             busy;

  // Upstream source plus both downstream sinks
  modport master (
    output in_data, in_valid, in_last, sel, a_ready, b_ready,
    input  in_ready, a_data, a_valid, a_last, b_data, b_valid, b_last, busy
  );

  // The demultiplexer itself
  modport slave (
    input  in_data, in_valid, in_last, sel, a_ready, b_ready,
    output in_ready, a_data, a_valid, a_last, b_data, b_valid, b_last, busy
  );
endinterface

// File: rtl/demux_1_to_2_stream.sv
// rtl/demux_1_to_2_stream.sv - packet-aware 1-to-2 stream demux; optional DEMUX_PKT_COUNT_EN adds per-output packet counters
module demux_1_to_2_stream #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_1_to_2_stream_if.slave  bus
`ifdef DEMUX_PKT_COUNT_EN
  ,
  output logic [15:0]           pkt_cnt_a,
  output logic [15:0]           pkt_cnt_b
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_data_q;
  logic             a_valid_q;
  logic             a_last_q;
  logic [WIDTH-1:0] b_data_q;
  logic             b_valid_q;
  logic             b_last_q;

  logic             a_free;
  logic             b_free;
  logic             route_b;
  logic             in_ready;
  logic             accept;

  // A register can take a new beat when empty or when its beat leaves this cycle
  assign a_free = !a_valid_q || bus.a_ready;
  assign b_free = !b_valid_q || bus.b_ready;
  assign accept = bus.in_valid && in_ready;

  // State register; reset drops any open packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: open a packet on a non-last first beat, close it on the last beat
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!bus.in_last) begin
            state_d = bus.sel ? ROUTE_B : ROUTE_A;
          end
        end
        ROUTE_A, ROUTE_B: begin
          if (bus.in_last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Routing decision and handshake: sel only matters in IDLE, afterwards the state is locked
  always_comb begin
    route_b  = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE:    route_b = bus.sel;
      ROUTE_B: route_b = 1'b1;
      default: route_b = 1'b0;
    endcase
    in_ready = route_b ? b_free : a_free;
  end

  // Output register A: load on routed accept, otherwise clear valid once taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data_q  <= '0;
      a_valid_q <= 1'b0;
      a_last_q  <= 1'b0;
    end else if (accept && !route_b) begin
      a_data_q  <= bus.in_data;
      a_valid_q <= 1'b1;
      a_last_q  <= bus.in_last;
    end else if (bus.a_ready) begin
      a_valid_q <= 1'b0;
    end
  end

  // Output register B: load on routed accept, otherwise clear valid once taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_last_q  <= 1'b0;
    end else if (accept && route_b) begin
      b_data_q  <= bus.in_data;
      b_valid_q <= 1'b1;
      b_last_q  <= bus.in_last;
    end else if (bus.b_ready) begin
      b_valid_q <= 1'b0;
    end
  end

`ifdef DEMUX_PKT_COUNT_EN
  // Count packets leaving each output on their last beat, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_a <= 16'd0;
      pkt_cnt_b <= 16'd0;
    end else begin
      if (a_valid_q && bus.a_ready && a_last_q && (pkt_cnt_a != 16'hFFFF)) begin
        pkt_cnt_a <= pkt_cnt_a + 16'd1;
      end
      if (b_valid_q && bus.b_ready && b_last_q && (pkt_cnt_b != 16'hFFFF)) begin
        pkt_cnt_b <= pkt_cnt_b + 16'd1;
      end
    end
  end
`endif

  assign bus.in_ready = in_ready;
  assign bus.busy     = (state_q != IDLE);
  assign bus.a_data   = a_data_q;
  assign bus.a_valid  = a_valid_q;
  assign bus.a_last   = a_last_q;
  assign bus.b_data   = b_data_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_last   = b_last_q;

endmodule

// File: tb/tb_demux_1_to_2_stream.sv
// tb/tb_demux_1_to_2_stream.sv - directed self-checking bench for demux_1_to_2_stream
module tb_demux_1_to_2_stream;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  demux_1_to_2_stream_if #(.WIDTH(8)) bus ();

`ifdef DEMUX_PKT_COUNT_EN
  logic [15:0] pkt_cnt_a;
  logic [15:0] pkt_cnt_b;
`endif

  demux_1_to_2_stream #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DEMUX_PKT_COUNT_EN
    ,
    .pkt_cnt_a (pkt_cnt_a),
    .pkt_cnt_b (pkt_cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic s);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.sel      = s;
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.sel      = 1'b0;
    bus.a_ready  = 1'b1;
    bus.b_ready  = 1'b1;
    repeat (3) tick();

    check("rst_a_valid", {15'd0, bus.a_valid}, 16'd0);
    check("rst_b_valid", {15'd0, bus.b_valid}, 16'd0);
    check("rst_a_data",  {8'd0, bus.a_data}, 16'h00);
    check("rst_b_last",  {15'd0, bus.b_last}, 16'd0);
    check("rst_busy",    {15'd0, bus.busy}, 16'd0);
`ifdef DEMUX_PKT_COUNT_EN
    check("rst_cnt_a", pkt_cnt_a, 16'd0);
    check("rst_cnt_b", pkt_cnt_b, 16'd0);
`endif
    rst_n = 1'b1;
    tick();

    // 3-beat packet to A
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    check("t1_in_ready", {15'd0, bus.in_ready}, 16'd1);
    tick();
    check("t1_b1_a_valid", {15'd0, bus.a_valid}, 16'd1);
    check("t1_b1_a_data",  {8'd0, bus.a_data}, 16'h11);
    check("t1_b1_busy",    {15'd0, bus.busy}, 16'd1);
    check("t1_b1_b_valid", {15'd0, bus.b_valid}, 16'd0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    check("t1_b2_a_data", {8'd0, bus.a_data}, 16'h22);
    check("t1_b2_a_last", {15'd0, bus.a_last}, 16'd0);
    check("t1_b2_busy",   {15'd0, bus.busy}, 16'd1);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    tick();
    check("t1_b3_a_data", {8'd0, bus.a_data}, 16'h33);
    check("t1_b3_a_last", {15'd0, bus.a_last}, 16'd1);
    check("t1_b3_busy",   {15'd0, bus.busy}, 16'd0);
    check("t1_b3_b_valid", {15'd0, bus.b_valid}, 16'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("t1_drain_a_valid", {15'd0, bus.a_valid}, 16'd0);

    // 3-beat packet to B, sel flips mid-packet and must be ignored
    drive(1'b1, 8'h44, 1'b0, 1'b1);
    tick();
    check("t2_b1_b_data", {8'd0, bus.b_data}, 16'h44);
    check("t2_b1_a_valid", {15'd0, bus.a_valid}, 16'd0);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    check("t2_b2_b_data", {8'd0, bus.b_data}, 16'h55);
    check("t2_b2_a_valid", {15'd0, bus.a_valid}, 16'd0);
    drive(1'b1, 8'h66, 1'b1, 1'b0);
    tick();
    check("t2_b3_b_data", {8'd0, bus.b_data}, 16'h66);
    check("t2_b3_b_last", {15'd0, bus.b_last}, 16'd1);
    check("t2_b3_a_valid", {15'd0, bus.a_valid}, 16'd0);
    check("t2_b3_busy", {15'd0, bus.busy}, 16'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("t2_drain_b_valid", {15'd0, bus.b_valid}, 16'd0);

    // A stalled for 4 cycles
    bus.a_ready = 1'b0;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    check("t3_load_a_data", {8'd0, bus.a_data}, 16'h77);
    drive(1'b1, 8'h88, 1'b0, 1'b1);
    check("t3_stall_in_ready", {15'd0, bus.in_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_a_data",  {8'd0, bus.a_data}, 16'h77);
      check("t3_hold_a_valid", {15'd0, bus.a_valid}, 16'd1);
      check("t3_hold_in_ready", {15'd0, bus.in_ready}, 16'd0);
      check("t3_hold_busy", {15'd0, bus.busy}, 16'd1);
    end
    bus.a_ready = 1'b1;
    #1;
    check("t3_release_in_ready", {15'd0, bus.in_ready}, 16'd1);
    tick();
    check("t3_b2_a_data",  {8'd0, bus.a_data}, 16'h88);
    check("t3_b2_a_valid", {15'd0, bus.a_valid}, 16'd1);
    check("t3_b2_b_valid", {15'd0, bus.b_valid}, 16'd0);
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    tick();
    check("t3_b3_a_data", {8'd0, bus.a_data}, 16'h99);
    check("t3_b3_a_last", {15'd0, bus.a_last}, 16'd1);
    check("t3_b3_busy", {15'd0, bus.busy}, 16'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("t3_drain_a_valid", {15'd0, bus.a_valid}, 16'd0);

    // Single-beat packets, B stalled must not block A
    bus.b_ready = 1'b0;
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    tick();
    check("t4_aa_a_data", {8'd0, bus.a_data}, 16'hAA);
    check("t4_aa_busy", {15'd0, bus.busy}, 16'd0);
    drive(1'b1, 8'hBB, 1'b1, 1'b1);
    check("t4_bb_in_ready", {15'd0, bus.in_ready}, 16'd1);
    tick();
    check("t4_bb_b_data",  {8'd0, bus.b_data}, 16'hBB);
    check("t4_bb_b_valid", {15'd0, bus.b_valid}, 16'd1);
    check("t4_bb_a_valid", {15'd0, bus.a_valid}, 16'd0);
    drive(1'b1, 8'hCC, 1'b1, 1'b0);
    check("t4_cc_in_ready", {15'd0, bus.in_ready}, 16'd1);
    tick();
    check("t4_cc_a_data",  {8'd0, bus.a_data}, 16'hCC);
    check("t4_cc_a_valid", {15'd0, bus.a_valid}, 16'd1);
    check("t4_cc_b_data",  {8'd0, bus.b_data}, 16'hBB);
    check("t4_cc_b_valid", {15'd0, bus.b_valid}, 16'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.b_ready = 1'b1;
    tick();
    check("t4_drain_a_valid", {15'd0, bus.a_valid}, 16'd0);
    check("t4_drain_b_valid", {15'd0, bus.b_valid}, 16'd0);
`ifdef DEMUX_PKT_COUNT_EN
    check("t4_cnt_a", pkt_cnt_a, 16'd4);
    check("t4_cnt_b", pkt_cnt_b, 16'd2);
`endif

    // Reset mid-packet after beat 2 of 4
    drive(1'b1, 8'hD1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'hD2, 1'b0, 1'b0);
    tick();
    check("t5_pre_busy", {15'd0, bus.busy}, 16'd1);
    check("t5_pre_a_data", {8'd0, bus.a_data}, 16'hD2);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("t5_rst_a_valid", {15'd0, bus.a_valid}, 16'd0);
    check("t5_rst_a_data",  {8'd0, bus.a_data}, 16'h00);
    check("t5_rst_busy",    {15'd0, bus.busy}, 16'd0);
`ifdef DEMUX_PKT_COUNT_EN
    check("t5_rst_cnt_a", pkt_cnt_a, 16'd0);
    check("t5_rst_cnt_b", pkt_cnt_b, 16'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_rel_a_valid", {15'd0, bus.a_valid}, 16'd0);
    drive(1'b1, 8'hE1, 1'b0, 1'b1);
    tick();
    check("t5_e1_b_data", {8'd0, bus.b_data}, 16'hE1);
    check("t5_e1_a_valid", {15'd0, bus.a_valid}, 16'd0);
    check("t5_e1_busy", {15'd0, bus.busy}, 16'd1);
    drive(1'b1, 8'hE2, 1'b1, 1'b0);
    tick();
    check("t5_e2_b_data", {8'd0, bus.b_data}, 16'hE2);
    check("t5_e2_b_last", {15'd0, bus.b_last}, 16'd1);
    check("t5_e2_a_valid", {15'd0, bus.a_valid}, 16'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("t5_drain_b_valid", {15'd0, bus.b_valid}, 16'd0);
`ifdef DEMUX_PKT_COUNT_EN
    check("t5_cnt_a", pkt_cnt_a, 16'd0);
    check("t5_cnt_b", pkt_cnt_b, 16'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
